// File: rtl/core_pipe_hazard_ctrl.sv
// Decode-side issue interlock: per-register writer scoreboard, forwarding select, drain sequencing.
// Optional perf counters are compiled in when CORE_HAZARD_PERF_EN is defined.
module core_pipe_hazard_ctrl #(
  parameter int CNT_W  = 2,
  parameter int INFL_W = 3
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              s1_valid,
  input  logic [4:0]        s1_rs1_addr,
  input  logic              s1_rs1_ren,
  input  logic [4:0]        s1_rs2_addr,
  input  logic              s1_rs2_ren,
  input  logic [4:0]        s1_rd,
  input  logic              s1_rd_wen,
  input  logic              s1_long,
  input  logic              s1_serial,
  input  logic              s3_ready,
  input  logic              wb_valid,
  input  logic              wb_wen,
  input  logic [4:0]        wb_rd,
  output logic              s2_issue,
  output logic              s2_stall,
  output logic              s2_rs1_fwd,
  output logic              s2_rs2_fwd,
  output logic              s2_draining,
  output logic [INFL_W-1:0] s2_inflight
`ifdef CORE_HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_issue_count
`endif
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DRAIN = 1'b1} state_t;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [INFL_W-1:0] INFL_ZERO = {INFL_W{1'b0}};
  localparam logic [INFL_W-1:0] INFL_ONE  = INFL_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt [32];
  logic [CNT_W-1:0]  w_cnt_nxt [32];
  logic [31:0]       r_lng;
  logic [31:0]       w_lng_nxt;
  logic [INFL_W-1:0] r_infl;
  logic [INFL_W-1:0] w_infl_nxt;

  logic w_rs1_busy;
  logic w_rs2_busy;
  logic w_rs1_haz;
  logic w_rs2_haz;
  logic w_sat;
  logic w_full;
  logic w_ser_block;
  logic w_issue;
  logic w_inc_en;
  logic w_dec_en;

  // Scoreboard lookups for the decoded instruction; x0 entries are never written, so stay zero
  always_comb begin
    w_rs1_busy  = s1_rs1_ren && (s1_rs1_addr != 5'd0) && (r_cnt[s1_rs1_addr] != CNT_ZERO);
    w_rs2_busy  = s1_rs2_ren && (s1_rs2_addr != 5'd0) && (r_cnt[s1_rs2_addr] != CNT_ZERO);
    w_rs1_haz   = w_rs1_busy && r_lng[s1_rs1_addr];
    w_rs2_haz   = w_rs2_busy && r_lng[s1_rs2_addr];
    w_sat       = s1_rd_wen && (s1_rd != 5'd0) && (&r_cnt[s1_rd]);
    w_full      = &r_infl;
    w_ser_block = s1_serial && (r_infl != INFL_ZERO);
    w_issue     = s1_valid && s3_ready && (r_state == ST_IDLE) && !w_rs1_haz && !w_rs2_haz
                  && !w_sat && !w_full && !w_ser_block;
  end

  // Scoreboard next state; an issue and retire to the same rd cancel out in the count
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_lng_nxt[i] = r_lng[i];
    end
    w_inc_en = w_issue && s1_rd_wen && (s1_rd != 5'd0);
    w_dec_en = wb_valid && wb_wen && (wb_rd != 5'd0) && (r_cnt[wb_rd] != CNT_ZERO);
    if (w_inc_en && w_dec_en && (s1_rd == wb_rd)) begin
      w_lng_nxt[s1_rd] = s1_long;
    end else begin
      if (w_inc_en) begin
        w_cnt_nxt[s1_rd] = r_cnt[s1_rd] + CNT_ONE;
        w_lng_nxt[s1_rd] = s1_long;
      end else begin
        w_lng_nxt[0] = 1'b0;
      end
      if (w_dec_en) begin
        w_cnt_nxt[wb_rd] = r_cnt[wb_rd] - CNT_ONE;
        if (r_cnt[wb_rd] == CNT_ONE) begin
          w_lng_nxt[wb_rd] = 1'b0;
        end else begin
          w_lng_nxt[0] = 1'b0;
        end
      end else begin
        w_lng_nxt[0] = 1'b0;
      end
    end
  end

  // In-flight count next state; a stray retire at zero holds the count
  always_comb begin
    w_infl_nxt = r_infl;
    case ({w_issue, wb_valid})
      2'b10:   w_infl_nxt = r_infl + INFL_ONE;
      2'b01: begin
        if (r_infl != INFL_ZERO) begin
          w_infl_nxt = r_infl - INFL_ONE;
        end else begin
          w_infl_nxt = r_infl;
        end
      end
      default: w_infl_nxt = r_infl;
    endcase
  end

  // Scoreboard and in-flight registers
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      for (int i = 0; i < 32; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
      r_lng  <= 32'd0;
      r_infl <= INFL_ZERO;
    end else begin
      for (int i = 0; i < 32; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_lng  <= w_lng_nxt;
      r_infl <= w_infl_nxt;
    end
  end

  // FSM state register
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: drain until empty, abandon the drain if decode is flushed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (s1_valid && s1_serial && (r_infl != INFL_ZERO)) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if ((r_infl == INFL_ZERO) || !s1_valid) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM and issue outputs
  always_comb begin
    s2_issue    = w_issue;
    s2_stall    = s1_valid && !w_issue;
    s2_rs1_fwd  = w_rs1_busy && !r_lng[s1_rs1_addr];
    s2_rs2_fwd  = w_rs2_busy && !r_lng[s1_rs2_addr];
    s2_draining = (r_state == ST_DRAIN);
    s2_inflight = r_infl;
  end

`ifdef CORE_HAZARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_issue;

  // Free-running wrap-around event counters
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_perf_stall <= 32'd0;
      r_perf_issue <= 32'd0;
    end else begin
      if (s1_valid && !w_issue) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end else begin
        r_perf_stall <= r_perf_stall;
      end
      if (w_issue) begin
        r_perf_issue <= r_perf_issue + 32'd1;
      end else begin
        r_perf_issue <= r_perf_issue;
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_issue_count  = r_perf_issue;
`endif

endmodule

// File: tb/tb_core_pipe_hazard_ctrl.sv
// Table-driven cycle-by-cycle bench for core_pipe_hazard_ctrl; expected values are hand-derived
// per cycle. Perf counter checks are included when CORE_HAZARD_PERF_EN is defined.
module tb_core_pipe_hazard_ctrl;

  logic       g_clk = 1'b0;
  logic       g_reset;
  logic       s1_valid, s1_rs1_ren, s1_rs2_ren, s1_rd_wen, s1_long, s1_serial, s3_ready;
  logic [4:0] s1_rs1_addr, s1_rs2_addr, s1_rd, wb_rd;
  logic       wb_valid, wb_wen;
  logic       s2_issue, s2_stall, s2_rs1_fwd, s2_rs2_fwd, s2_draining;
  logic [2:0] s2_inflight;
`ifdef CORE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_issue_count;
`endif

  core_pipe_hazard_ctrl #(.CNT_W(2), .INFL_W(3)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .s1_valid(s1_valid),
    .s1_rs1_addr(s1_rs1_addr), .s1_rs1_ren(s1_rs1_ren),
    .s1_rs2_addr(s1_rs2_addr), .s1_rs2_ren(s1_rs2_ren),
    .s1_rd(s1_rd), .s1_rd_wen(s1_rd_wen), .s1_long(s1_long), .s1_serial(s1_serial),
    .s3_ready(s3_ready), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .s2_issue(s2_issue), .s2_stall(s2_stall), .s2_rs1_fwd(s2_rs1_fwd),
    .s2_rs2_fwd(s2_rs2_fwd), .s2_draining(s2_draining), .s2_inflight(s2_inflight)
`ifdef CORE_HAZARD_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_issue_count(perf_issue_count)
`endif
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic       rst, v;
    logic [4:0] rs1;
    logic       e1;
    logic [4:0] rs2;
    logic       e2;
    logic [4:0] rd;
    logic       w, l, s, rdy, wbv, wbw;
    logic [4:0] wbrd;
    logic       x_iss, x_stl, x_f1, x_f2, x_drn;
    logic [2:0] x_inf;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_pstall = 0;
  int   exp_pissue = 0;

  task automatic row(input int rst, v, rs1, e1, rs2, e2, rd, w, l, s, rdy, wbv, wbw, wbrd,
                     iss, stl, f1, f2, drn, inf);
    vec_t t;
    t.rst = 1'(rst); t.v = 1'(v); t.rs1 = 5'(rs1); t.e1 = 1'(e1); t.rs2 = 5'(rs2); t.e2 = 1'(e2);
    t.rd = 5'(rd); t.w = 1'(w); t.l = 1'(l); t.s = 1'(s); t.rdy = 1'(rdy);
    t.wbv = 1'(wbv); t.wbw = 1'(wbw); t.wbrd = 5'(wbrd);
    t.x_iss = 1'(iss); t.x_stl = 1'(stl); t.x_f1 = 1'(f1); t.x_f2 = 1'(f2); t.x_drn = 1'(drn);
    t.x_inf = 3'(inf);
    tbl.push_back(t);
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    g_reset = t.rst; s1_valid = t.v; s1_rs1_addr = t.rs1; s1_rs1_ren = t.e1;
    s1_rs2_addr = t.rs2; s1_rs2_ren = t.e2; s1_rd = t.rd; s1_rd_wen = t.w; s1_long = t.l;
    s1_serial = t.s; s3_ready = t.rdy; wb_valid = t.wbv; wb_wen = t.wbw; wb_rd = t.wbrd;
  endtask

  initial begin
    // row(rst,v, rs1,e1, rs2,e2, rd,w,l,s,rdy, wbv,wbw,wbrd, iss,stl,f1,f2,drn,inf)
    // Basic issue and forwarding of a short result; x0 never tracked
    row(0,1, 0,0, 0,0, 5,1,0,0,1, 0,0,0, 1,0,0,0,0,0);
    row(0,1, 5,1, 0,0, 6,1,0,0,1, 0,0,0, 1,0,1,0,0,1);
    row(0,0, 0,0, 0,0, 0,0,0,0,0, 1,1,5, 0,0,0,0,0,2);
    row(0,0, 0,0, 0,0, 0,0,0,0,0, 1,1,6, 0,0,0,0,0,1);
    row(0,1, 5,1, 0,0, 0,0,0,0,0, 0,0,0, 0,1,0,0,0,0);
    row(0,1, 0,1, 0,0, 0,1,1,0,1, 0,0,0, 1,0,0,0,0,0);
    row(0,1, 0,0, 0,1, 0,0,0,0,1, 0,0,0, 1,0,0,0,0,1);
    row(0,0, 0,0, 0,0, 0,0,0,0,0, 1,1,0, 0,0,0,0,0,2);
    row(0,0, 0,0, 0,0, 0,0,0,0,0, 1,0,0, 0,0,0,0,0,1);
    // Long load to x7; consumer stalls until the cycle after its retire
    row(0,1, 0,0, 0,0, 7,1,1,0,1, 0,0,0, 1,0,0,0,0,0);
    row(0,1, 0,0, 7,1, 8,1,0,0,1, 0,0,0, 0,1,0,0,0,1);
    row(0,1, 0,0, 7,1, 8,1,0,0,1, 1,1,7, 0,1,0,0,0,1);
    row(0,1, 0,0, 7,1, 8,1,0,0,1, 0,0,0, 1,0,0,0,0,0);
    row(0,0, 0,0, 0,0, 0,0,0,0,0, 1,1,8, 0,0,0,0,0,1);
    // WAW saturation on x3
    for (int k = 0; k < 3; k++) row(0,1, 0,0, 0,0, 3,1,0,0,1, 0,0,0, 1,0,0,0,0,k);
    row(0,1, 0,0, 0,0, 3,1,0,0,1, 0,0,0, 0,1,0,0,0,3);
    row(0,1, 0,0, 0,0, 3,1,0,0,1, 1,1,3, 0,1,0,0,0,3);
    row(0,1, 0,0, 0,0, 3,1,0,0,1, 0,0,0, 1,0,0,0,0,2);
    for (int k = 3; k > 0; k--) row(0,0, 0,0, 0,0, 0,0,0,0,0, 1,1,3, 0,0,0,0,0,k);
    // In-flight full at 7
    for (int k = 0; k < 7; k++) row(0,1, 0,0, 0,0, 0,0,0,0,1, 0,0,0, 1,0,0,0,0,k);
    row(0,1, 0,0, 0,0, 0,0,0,0,1, 0,0,0, 0,1,0,0,0,7);
    row(0,1, 0,0, 0,0, 0,0,0,0,1, 1,0,0, 0,1,0,0,0,7);
    row(0,1, 0,0, 0,0, 0,0,0,0,1, 0,0,0, 1,0,0,0,0,6);
    for (int k = 7; k > 0; k--) row(0,0, 0,0, 0,0, 0,0,0,0,0, 1,0,0, 0,0,0,0,0,k);
    // Serial instruction drains two in-flight writers
    row(0,1, 0,0, 0,0, 9,1,0,0,1, 0,0,0, 1,0,0,0,0,0);
    row(0,1, 0,0, 0,0, 10,1,0,0,1, 0,0,0, 1,0,0,0,0,1);
    row(0,1, 0,0, 0,0, 0,0,0,1,1, 0,0,0, 0,1,0,0,0,2);
    row(0,1, 10,1, 0,0, 0,0,0,1,1, 1,1,9, 0,1,1,0,1,2);
    row(0,1, 0,0, 0,0, 0,0,0,1,1, 1,1,10, 0,1,0,0,1,1);
    row(0,1, 0,0, 0,0, 0,0,0,1,1, 0,0,0, 0,1,0,0,1,0);
    row(0,1, 0,0, 0,0, 0,0,0,1,1, 0,0,0, 1,0,0,0,0,0);
    row(0,0, 0,0, 0,0, 0,0,0,0,0, 1,0,0, 0,0,0,0,0,1);
    // Decode flush abandons a drain
    row(0,1, 0,0, 0,0, 0,0,0,0,1, 0,0,0, 1,0,0,0,0,0);
    row(0,1, 0,0, 0,0, 0,0,0,1,1, 0,0,0, 0,1,0,0,0,1);
    row(0,0, 0,0, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,1,1);
    row(0,0, 0,0, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,1);
    row(0,0, 0,0, 0,0, 0,0,0,0,0, 1,0,0, 0,0,0,0,0,1);
    // Same-cycle issue and retire of x4; youngest writer is long
    row(0,1, 0,0, 0,0, 4,1,0,0,1, 0,0,0, 1,0,0,0,0,0);
    row(0,1, 0,0, 0,0, 4,1,1,0,1, 1,1,4, 1,0,0,0,0,1);
    row(0,1, 4,1, 0,0, 0,0,0,0,1, 0,0,0, 0,1,0,0,0,1);
    row(0,1, 4,1, 0,0, 0,0,0,0,1, 1,1,4, 0,1,0,0,0,1);
    row(0,1, 4,1, 0,0, 0,0,0,0,1, 0,0,0, 1,0,0,0,0,0);
    row(0,0, 0,0, 0,0, 0,0,0,0,0, 1,0,0, 0,0,0,0,0,1);
    // Reset while draining with three long writers to x11
    for (int k = 0; k < 3; k++) row(0,1, 0,0, 0,0, 11,1,1,0,1, 0,0,0, 1,0,0,0,0,k);
    row(0,1, 0,0, 0,0, 0,0,0,1,1, 0,0,0, 0,1,0,0,0,3);
    row(1,1, 11,1, 0,0, 0,0,0,1,1, 0,0,0, 0,1,0,0,1,3);
    row(0,1, 11,1, 11,1, 0,0,0,0,1, 0,0,0, 1,0,0,0,0,0);
    row(0,0, 0,0, 0,0, 0,0,0,0,0, 1,0,0, 0,0,0,0,0,1);

    // Initial reset
    drive(tbl[0]);
    g_reset = 1'b1; s1_valid = 1'b0; wb_valid = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge g_clk);
      check("issue",    i, 32'(s2_issue),    32'(tbl[i].x_iss));
      check("stall",    i, 32'(s2_stall),    32'(tbl[i].x_stl));
      check("rs1_fwd",  i, 32'(s2_rs1_fwd),  32'(tbl[i].x_f1));
      check("rs2_fwd",  i, 32'(s2_rs2_fwd),  32'(tbl[i].x_f2));
      check("draining", i, 32'(s2_draining), 32'(tbl[i].x_drn));
      check("inflight", i, 32'(s2_inflight), 32'(tbl[i].x_inf));
      if (tbl[i].wbv) check("wb_legal", i, 32'(s2_inflight != 3'd0), 32'd1);
`ifdef CORE_HAZARD_PERF_EN
      check("perf_stall", i, perf_stall_cycles, 32'(exp_pstall));
      check("perf_issue", i, perf_issue_count,  32'(exp_pissue));
`endif
      if (tbl[i].rst) begin
        exp_pstall = 0;
        exp_pissue = 0;
      end else begin
        exp_pstall += int'(tbl[i].x_stl);
        exp_pissue += int'(tbl[i].x_iss);
      end
      @(posedge g_clk);
      #1;
    end

    // Final reset with a stalled instruction presented: execute not ready
    g_reset = 1'b1; s1_valid = 1'b1; s3_ready = 1'b0; s1_serial = 1'b0;
    s1_rs1_ren = 1'b0; s1_rs2_ren = 1'b0; s1_rd_wen = 1'b0; wb_valid = 1'b0;
    @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    @(negedge g_clk);
    check("rst_issue",    0, 32'(s2_issue),    32'd0);
    check("rst_stall",    0, 32'(s2_stall),    32'd1);
    check("rst_draining", 0, 32'(s2_draining), 32'd0);
    check("rst_inflight", 0, 32'(s2_inflight), 32'd0);
`ifdef CORE_HAZARD_PERF_EN
    check("rst_perf_stall", 0, perf_stall_cycles, 32'd0);
    check("rst_perf_issue", 0, perf_issue_count,  32'd0);
`endif
    @(posedge g_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_pipe_hazard_ctrl.md
Name: core_pipe_hazard_ctrl

Overview:
- Issue/interlock controller sitting beside the decode stage.
- Keeps a per-register scoreboard of in-flight writers and a total in-flight count.
- Decides each cycle whether the decoded instruction may issue to execute, and tells the operand-gather logic when a source must come from the forwarding network.
- Sequences serialising instructions (fence.i, CSR writes) by draining the pipeline before letting them issue.

Parameters:
- CNT_W, 2, width of per-register pending-writer counter; max writers to one rd = 2^CNT_W-1.
- INFL_W, 3, width of total in-flight instruction counter; max in flight = 2^INFL_W-1.

Ports:
- g_clk  in  1  global clock.
- g_reset  in  1  synchronous active-high reset.
- s1_valid  in  1  decode holds a valid instruction.
- s1_rs1_addr  in  5  source 1 register.
- s1_rs1_ren  in  1  source 1 is read.
- s1_rs2_addr  in  5  source 2 register.
- s1_rs2_ren  in  1  source 2 is read.
- s1_rd  in  5  destination register.
- s1_rd_wen  in  1  instruction writes rd.
- s1_long  in  1  result comes from LSU/MDU (not forwardable).
- s1_serial  in  1  instruction must issue into an empty pipeline.
- s3_ready  in  1  execute accepts an instruction.
- wb_valid  in  1  one issued instruction retires (committed or killed).
- wb_wen  in  1  retiring instruction had s1_rd_wen set.
- wb_rd  in  5  rd of retiring instruction.
- s2_issue  out  1  instruction issues this cycle.
- s2_stall  out  1  s1_valid && !s2_issue.
- s2_rs1_fwd  out  1  rs1 must be taken from the forwarding network.
- s2_rs2_fwd  out  1  rs2 must be taken from the forwarding network.
- s2_draining  out  1  FSM is in DRAIN.
- s2_inflight  out  INFL_W  current in-flight count.

Behaviour:
- State: cnt[1..31] (CNT_W bits), lng[1..31] (1 bit), inflight (INFL_W bits), FSM {IDLE, DRAIN}. x0 is never tracked; reads of x0 never stall or forward.
- Reset: all cnt, lng, inflight = 0, FSM = IDLE. Resulting outputs: s2_issue = s1_valid && s3_ready (non-serial case), s2_stall = s1_valid && !s3_ready, fwd = 0, s2_draining = 0, s2_inflight = 0. Reset mid-drain returns to IDLE with an empty scoreboard.
- All outputs are combinational from registered state plus current s1 inputs. A same-cycle retire does not unblock issue; its effect is visible next cycle.
- Source hazard (per rsN): rsN_ren && rsN != 0 && cnt[rsN] != 0 && lng[rsN].
- Forward (per rsN): s2_rsN_fwd = rsN_ren && rsN != 0 && cnt[rsN] != 0 && !lng[rsN].
- WAW saturation: s1_rd_wen && s1_rd != 0 && cnt[s1_rd] is all ones.
- In-flight full: inflight is all ones.
- s2_issue = s1_valid && s3_ready && FSM == IDLE && no source hazard && no saturation && !full && !(s1_serial && inflight != 0).
- On issue: inflight += 1. If s1_rd_wen && rd != 0: cnt[rd] += 1 and lng[rd] = s1_long (youngest writer's class).
- On wb_valid: inflight -= 1. If wb_wen && wb_rd != 0: cnt[wb_rd] -= 1; when it reaches 0, lng[wb_rd] = 0.
- Simultaneous issue and retire:
  - inflight is unchanged.
  - Same rd: cnt is unchanged and lng = s1_long.
- Retirement is in program order. Every issued instruction produces exactly one wb_valid.
- wb_valid with inflight == 0, or a decrement of cnt == 0, is illegal. RTL holds the value at 0; the bench asserts it never happens.
- FSM:
  - IDLE -> DRAIN when s1_valid && s1_serial && inflight != 0.
  - DRAIN -> IDLE when inflight == 0 (registered), or when s1_valid drops (decode flushed).
  - The serial instruction issues from IDLE on the cycle after return, subject to the normal rules.

Optional Feature:
- Macro: CORE_HAZARD_PERF_EN.
- When defined, adds outputs perf_stall_cycles (32 bits) and perf_issue_count (32 bits).
  - perf_stall_cycles increments on every cycle where s1_valid && !s2_issue.
  - perf_issue_count increments on every s2_issue.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset, then s1_valid=1, rd=5, wen=1, long=0, s3_ready=1 -> s2_issue=1; next cycle the instruction reads rs1=5 -> s2_rs1_fwd=1, s2_issue=1.
- Issue a load to x7 (long=1), then an instruction reading rs2=7 -> s2_stall=1 until one cycle after wb_valid, wb_wen=1, wb_rd=7; then s2_issue=1, s2_rs2_fwd=0.
- Issue three writers to x3 without retire, then a fourth to x3 -> stalled (cnt=3 saturation); retire one -> the fourth issues the next cycle.
- Two instructions in flight, then s1_serial=1 -> s2_draining=1 and stall; after two wb_valid pulses -> IDLE, and the serial instruction issues one cycle later with s2_inflight going 0 -> 1.
- Same cycle: issue to x4 (long=1) and retire x4 with cnt[x4]=1 -> cnt stays 1, lng=1; a consumer of x4 stalls.
- Reset asserted while in DRAIN with inflight=3 -> next cycle FSM=IDLE, s2_inflight=0, all fwd=0; with PERF enabled both counters read 0.
